full_adder: RTL and testbench

Registered, width-parameterised binary adder: adds two WIDTH-bit operands and a carry-in, producing a WIDTH-bit sum, carry-out and signed-overflow flag one clock after a valid input. At WIDTH=1 it is the classic single-bit full adder. It is the arithmetic leaf cell for datapaths that need a clocked add with carry chaining. Larger adders cascade instances by feeding Carry_out into Carry_in.

---
 rtl/full_adder_if.sv | 24 ++
 rtl/full_adder.sv | 60 ++++++
 tb/tb_full_adder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder.
// The master drives operands; the slave (the adder) returns the registered result.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Carry_in;
    logic             in_valid;
    logic [WIDTH-1:0] Sum;
    logic             Carry_out;
    logic             Overflow;
    logic             out_valid;

    modport master (
        output A, B, Carry_in, in_valid,
        input  Sum, Carry_out, Overflow, out_valid
    );

    modport slave (
        input  A, B, Carry_in, in_valid,
        output Sum, Carry_out, Overflow, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry-out and signed overflow.
// The result is captured one clock after a valid operand set.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    full_adder_if.slave bus
);
    logic [WIDTH-1:0] sum_next;
    logic             carry_out_next;
    logic             overflow_next;

    logic [WIDTH-1:0] sum_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             out_valid_reg;

    // Each cell keeps its own carry nets so the chain is not one self-referencing vector.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        logic carry_into;
        logic carry_from;

        if (gi == 0) begin : g_first
            assign carry_into = bus.Carry_in;
        end else begin : g_rest
            assign carry_into = g_cell[gi-1].carry_from;
        end

        assign sum_next[gi] = bus.A[gi] ^ bus.B[gi] ^ carry_into;
        assign carry_from   = (bus.A[gi] & bus.B[gi])
                            | (bus.A[gi] & carry_into)
                            | (bus.B[gi] & carry_into);
    end

    assign carry_out_next = g_cell[WIDTH-1].carry_from;
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign overflow_next  = g_cell[WIDTH-1].carry_from ^ g_cell[WIDTH-1].carry_into;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                sum_reg       <= sum_next;
                carry_out_reg <= carry_out_next;
                overflow_reg  <= overflow_next;
            end
        end
    end

    assign bus.Sum       = sum_reg;
    assign bus.Carry_out = carry_out_reg;
    assign bus.Overflow  = overflow_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: fixed vectors at WIDTH=1 and WIDTH=8, hold/reset sequences,
// then randomized operands against an integer-arithmetic reference.
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string     name;
        int        w;
        logic [7:0] a;
        logic [7:0] b;
        logic      cin;
        logic [7:0] sum;
        logic      co;
        logic      ov;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer add plus signed range test on the true signed result.
    task automatic ref_add(input int w, input int a, input int b, input int cin,
                           output int sum, output int co, output int ov);
        int full, sa, sb, sres, lim;
        full = a + b + cin;
        sum  = full % (1 << w);
        co   = full >> w;
        lim  = 1 << (w - 1);
        sa   = (a >= lim) ? a - (1 << w) : a;
        sb   = (b >= lim) ? b - (1 << w) : b;
        sres = sa + sb + cin;
        ov   = (sres > lim - 1 || sres < -lim) ? 1 : 0;
    endtask

    task automatic idle_inputs();
        if1.in_valid = 1'b0; if1.A = 1'b0; if1.B = 1'b0; if1.Carry_in = 1'b0;
        if8.in_valid = 1'b0; if8.A = 8'h00; if8.B = 8'h00; if8.Carry_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w1(input string name, input int s, input int co, input int ov, input int v);
        check({name, ".sum"},  32'(if1.Sum),       32'(s));
        check({name, ".co"},   32'(if1.Carry_out), 32'(co));
        check({name, ".ov"},   32'(if1.Overflow),  32'(ov));
        check({name, ".vld"},  32'(if1.out_valid), 32'(v));
    endtask

    task automatic check_w8(input string name, input int s, input int co, input int ov, input int v);
        check({name, ".sum"},  32'(if8.Sum),       32'(s));
        check({name, ".co"},   32'(if8.Carry_out), 32'(co));
        check({name, ".ov"},   32'(if8.Overflow),  32'(ov));
        check({name, ".vld"},  32'(if8.out_valid), 32'(v));
    endtask

    initial begin
        int es1, ec1, eo1, ev1, es8, ec8, eo8, ev8;

        // name, width, A, B, Cin, Sum, Cout, Ovf
        vecs.push_back('{"seq_1_0",  1, 8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0});
        vecs.push_back('{"seq_1_1",  1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1});
        vecs.push_back('{"seq_0_0",  1, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0});
        vecs.push_back('{"tt_000",   1, 8'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0});
        vecs.push_back('{"tt_001",   1, 8'h0, 8'h0, 1'b1, 8'h1, 1'b0, 1'b1});
        vecs.push_back('{"tt_010",   1, 8'h0, 8'h1, 1'b0, 8'h1, 1'b0, 1'b0});
        vecs.push_back('{"tt_011",   1, 8'h0, 8'h1, 1'b1, 8'h0, 1'b1, 1'b0});
        vecs.push_back('{"tt_100",   1, 8'h1, 8'h0, 1'b0, 8'h1, 1'b0, 1'b0});
        vecs.push_back('{"tt_101",   1, 8'h1, 8'h0, 1'b1, 8'h0, 1'b1, 1'b0});
        vecs.push_back('{"tt_110",   1, 8'h1, 8'h1, 1'b0, 8'h0, 1'b1, 1'b1});
        vecs.push_back('{"tt_111",   1, 8'h1, 8'h1, 1'b1, 8'h1, 1'b1, 1'b0});
        vecs.push_back('{"w8_ff_01", 8, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"w8_7f_01", 8, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"w8_ff_ff", 8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{"w8_80_80", 8, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{"w8_03_04", 8, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0});

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_w1("reset_w1", 0, 0, 0, 0);
        check_w8("reset_w8", 0, 0, 0, 0);
        rst = 1'b0;

        // Table vectors: drive one width at a time, result visible after the next edge.
        foreach (vecs[i]) begin
            idle_inputs();
            if (vecs[i].w == 1) begin
                if1.A = vecs[i].a[0]; if1.B = vecs[i].b[0];
                if1.Carry_in = vecs[i].cin; if1.in_valid = 1'b1;
                tick();
                check_w1(vecs[i].name, int'(vecs[i].sum), int'(vecs[i].co), int'(vecs[i].ov), 1);
            end else begin
                if8.A = vecs[i].a; if8.B = vecs[i].b;
                if8.Carry_in = vecs[i].cin; if8.in_valid = 1'b1;
                tick();
                check_w8(vecs[i].name, int'(vecs[i].sum), int'(vecs[i].co), int'(vecs[i].ov), 1);
            end
        end

        // Hold: 0x03+0x04 was last loaded; drop valid and disturb operands.
        idle_inputs();
        if8.A = 8'hAA; if8.B = 8'h11; if8.Carry_in = 1'b1;
        #2;
        check_w8("hold_between_edges", 8'h07, 0, 0, 1);
        tick();
        check_w8("hold_1", 8'h07, 0, 0, 0);
        tick();
        check_w8("hold_2", 8'h07, 0, 0, 0);

        // Reset mid-stream with 1+1 pending at WIDTH=1.
        idle_inputs();
        if1.A = 1'b1; if1.B = 1'b1; if1.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        check_w1("midrst", 0, 0, 0, 0);
        rst = 1'b0;
        if1.A = 1'b1; if1.B = 1'b0; if1.Carry_in = 1'b0;
        tick();
        check_w1("after_rst", 1, 0, 0, 1);

        // Random: 1000 back-to-back cycles, then sparse valid.
        ref_add(1, int'(if1.A), int'(if1.B), int'(if1.Carry_in), es1, ec1, eo1);
        ev1 = 1;
        es8 = 8'h07; ec8 = 0; eo8 = 0; ev8 = 0;
        for (int i = 0; i < 1200; i++) begin
            logic v1, v8;
            v1 = (i < 1000) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            v8 = (i < 1000) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
            if1.A = 1'($urandom); if1.B = 1'($urandom);
            if1.Carry_in = 1'($urandom); if1.in_valid = v1;
            if8.A = 8'($urandom); if8.B = 8'($urandom);
            if8.Carry_in = 1'($urandom); if8.in_valid = v8;
            if (v1) ref_add(1, int'(if1.A), int'(if1.B), int'(if1.Carry_in), es1, ec1, eo1);
            if (v8) ref_add(8, int'(if8.A), int'(if8.B), int'(if8.Carry_in), es8, ec8, eo8);
            ev1 = int'(v1);
            ev8 = int'(v8);
            tick();
            check_w1("rand_w1", es1, ec1, eo1, ev1);
            check_w8("rand_w8", es8, ec8, eo8, ev8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
